// File: rtl/rr_mux_arbiter.sv
`timescale 1ns/1ps
// rr_mux_arbiter
//
// Round-robin arbiter plus output register that sits in front of mux4to1.
// Each cycle it picks one of four requesting sources, captures that source's
// word into a valid/ready output register, drives the registered select pair
// for mux4to1, and returns a one-cycle grant pulse to the winning source.
//
// Optional build macro: RR_MUX_STATS_EN adds a saturating 16-bit count of
// completed output transfers (o_xfer_cnt).
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_req[3:0]  request level per source (bit n = source n has a word)
//   i_0..i_3    source words, DATA_W bits each
//   o_grant     one-hot, one-cycle pulse: source n's word was taken
//   o_sel1/0    registered select pair, winner index {MSB, LSB}
//   o_data      registered selected word
//   o_valid     o_data holds a word not yet taken downstream
//   i_ready     downstream accepts o_data when o_valid & i_ready
//   o_xfer_cnt  (RR_MUX_STATS_EN only) completed transfers, saturating
//
// Handshake: a word moves downstream on every rising edge where o_valid and
// i_ready are both high. o_valid depends only on registered state, never
// combinationally on i_ready; i_ready is ignored while o_valid is low.
module rr_mux_arbiter #(
    parameter int DATA_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_req,
    input  logic [DATA_W-1:0] i_0,
    input  logic [DATA_W-1:0] i_1,
    input  logic [DATA_W-1:0] i_2,
    input  logic [DATA_W-1:0] i_3,
    output logic [3:0]        o_grant,
    output logic              o_sel1,
    output logic              o_sel0,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready
`ifdef RR_MUX_STATS_EN
    ,
    output logic [15:0]       o_xfer_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        ptr_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        grant_q;

    logic [3:0]        masked;
    logic              found;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic [DATA_W-1:0] win_data;
    logic              load;

    // A source that sees its grant this cycle may still be showing the
    // request it just had serviced; clearing it prevents a double take.
    assign masked = i_req & ~grant_q;

    // First set bit of the masked request, scanning from ptr upward mod 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && masked[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_data = i_0;
        case (win)
            2'd0: win_data = i_0;
            2'd1: win_data = i_1;
            2'd2: win_data = i_2;
            2'd3: win_data = i_3;
            default: win_data = i_0;
        endcase
    end

    // Next state: load whenever the register is empty or being emptied this
    // cycle and someone is requesting.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            data_q  <= '0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            grant_q <= load ? (4'b0001 << win) : 4'b0000;
            if (load) begin
                data_q <= win_data;
                sel_q  <= win;
                ptr_q  <= win + 2'd1;
            end
        end
    end

    assign o_valid = (state_q == HOLD);
    assign o_grant = grant_q;
    assign o_data  = data_q;
    assign o_sel1  = sel_q[1];
    assign o_sel0  = sel_q[0];

`ifdef RR_MUX_STATS_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            xfer_cnt_q <= 16'd0;
        end else if (o_valid && i_ready && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
`timescale 1ns/1ps
// Directed bench for rr_mux_arbiter: reset, single source, round robin,
// back-pressure with pointer wrap, stale-request masking and (with
// RR_MUX_STATS_EN) transfer-counter saturation.
module tb_rr_mux_arbiter;

    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   grant;
    logic         sel1, sel0;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
`ifdef RR_MUX_STATS_EN
    logic [15:0]  xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_mux_arbiter #(.DATA_W(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_0     (d0),
        .i_1     (d1),
        .i_2     (d2),
        .i_3     (d3),
        .o_grant (grant),
        .o_sel1  (sel1),
        .o_sel0  (sel0),
        .o_data  (data),
        .o_valid (valid),
        .i_ready (ready)
`ifdef RR_MUX_STATS_EN
        ,
        .o_xfer_cnt (xfer_cnt)
`endif
    );

    // driver: advance one clock, land 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] g,
                             input logic [1:0] s, input logic [W-1:0] dd);
        check({tag, "_valid"}, 32'(valid), 32'(v));
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_sel"},   32'({sel1, sel0}), 32'(s));
        check({tag, "_data"},  32'(data), 32'(dd));
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; ready = 1'b1;
        d0 = 2'b00; d1 = 2'b01; d2 = 2'b10; d3 = 2'b11;

        // Reset with every source requesting
        tick(); tick();
        check_out("reset", 1'b0, 4'b0000, 2'b00, 2'b00);
        rst = 1'b0;
        check("post_reset_grant", 32'(grant), 32'd0);
        tick();
        check_out("first_load", 1'b1, 4'b0001, 2'b00, 2'b00);
        req = 4'b0000;
        tick();
        check("drain_valid", 32'(valid), 32'd0);

        // Single source 2 (ptr is 1 here)
        req = 4'b0100;
        tick();
        check_out("single", 1'b1, 4'b0100, 2'b10, 2'b10);
        req = 4'b0000;
        tick();
        check_out("single_idle", 1'b0, 4'b0000, 2'b10, 2'b10);

        // Round robin from ptr=0, all requesting, ready high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111; ready = 1'b1;
        exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b11); exp_q.push_back(2'b00);
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            tick();
            check_out("rr", 1'b1, 4'b0001 << e, e, e);
        end
        req = 4'b0000;
        tick();
        check("rr_idle_valid", 32'(valid), 32'd0);

        // Back-pressure: hold channel 3, then ptr wraps to channel 0
        req = 4'b1000; ready = 1'b0;
        tick();
        check_out("bp_load", 1'b1, 4'b1000, 2'b11, 2'b11);
        req = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("bp_hold", 1'b1, 4'b0000, 2'b11, 2'b11);
        end
        ready = 1'b1;
        tick();
        check_out("bp_release", 1'b1, 4'b0001, 2'b00, 2'b00);
        req = 4'b0000;
        tick();
        check("bp_idle_valid", 32'(valid), 32'd0);

        // Stale request held one cycle past its grant must not be retaken
        req = 4'b0010; ready = 1'b1;
        tick();
        check_out("mask_load", 1'b1, 4'b0010, 2'b01, 2'b01);
        tick();
        check_out("mask_stale", 1'b0, 4'b0000, 2'b01, 2'b01);
        req = 4'b0000;
        tick();
        check_out("mask_after", 1'b0, 4'b0000, 2'b01, 2'b01);

`ifdef RR_MUX_STATS_EN
        // Counter saturation and reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_reset", 32'(xfer_cnt), 32'd0);
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        check("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0000;
        check("cnt_clear", 32'(xfer_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
